// File: rtl/shifter_pkg.sv
// Shared mode encodings and stage-partitioning helpers for the pipelined shifter.
// Modes 000-010 keep the legacy 2-bit shifter encoding, zero-extended.
package shifter_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t SH_SRL = 3'b000;
    localparam mode_t SH_SLL = 3'b001;
    localparam mode_t SH_SRA = 3'b010;
    localparam mode_t SH_ROR = 3'b011;
    localparam mode_t SH_ROL = 3'b100;

    // Binary steps handled by stage idx; earlier stages absorb the remainder.
    function automatic int steps_in_stage(input int shw, input int stages, input int idx);
        return shw / stages + ((idx < shw % stages) ? 1 : 0);
    endfunction

    // Index of the first binary step handled by stage idx.
    function automatic int first_step(input int shw, input int stages, input int idx);
        int lo;
        lo = 0;
        for (int i = 0; i < idx; i++) begin
            lo += steps_in_stage(shw, stages, i);
        end
        return lo;
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Valid/ready bundle for the pipelined shifter: operation in, result out.
// master = producer/consumer around the block, slave = the shifter itself.
interface pipelined_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [SHW-1:0]   in_shamt;
    mode_t            in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_shamt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_r, out_tag, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_shamt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_tag, out_zero
    );

endinterface

// File: rtl/shift_stage.sv
// Combinational slice of the shifter: applies binary steps LO..HI, where step k
// moves the operand by 2^k positions when amt[k] is set.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LO    = 0,
    parameter int HI    = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [HI:LO]     amt,
    input  mode_t            mode,
    output logic [WIDTH-1:0] r
);

    // NOTE: blocking assignments chain each step onto the previous one, and the
    // default assignment of d before the loop keeps this block latch-free.
    logic [WIDTH-1:0] d;

    always_comb begin
        d = a;
        for (int k = LO; k <= HI; k++) begin
            if (amt[k]) begin
                case (mode)
                    SH_SRL:  d = d >> (1 << k);
                    SH_SLL:  d = d << (1 << k);
                    // The MSB survives every arithmetic step, so it is still the original sign.
                    SH_SRA:  d = $signed(d) >>> (1 << k);
                    SH_ROR:  d = (d >> (1 << k)) | (d << (WIDTH - (1 << k)));
                    SH_ROL:  d = (d << (1 << k)) | (d >> (WIDTH - (1 << k)));
                    default: d = d;
                endcase
            end
        end
    end

    assign r = d;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined logical/arithmetic/rotate shifter with a tag sideband and a
// whole-pipe stall: every stage advances together or holds together.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input logic                clk,
    input logic                rst_n,
    pipelined_shifter_if.slave bus
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int LAST = PIPE_STAGES - 1;

    logic             advance;

    logic             v_in    [PIPE_STAGES];
    logic [WIDTH-1:0] d_in    [PIPE_STAGES];
    logic [SHW-1:0]   sh_in   [PIPE_STAGES];
    mode_t            mode_in [PIPE_STAGES];
    logic [TAG_W-1:0] tag_in  [PIPE_STAGES];
    logic [WIDTH-1:0] d_out   [PIPE_STAGES];

    logic             v_q     [PIPE_STAGES];
    logic [WIDTH-1:0] d_q     [PIPE_STAGES];
    logic [SHW-1:0]   sh_q    [PIPE_STAGES];
    mode_t            mode_q  [PIPE_STAGES];
    logic [TAG_W-1:0] tag_q   [PIPE_STAGES];

    // A full output slot that is not being taken blocks the whole pipe.
    assign advance      = !v_q[LAST] || bus.out_ready;
    assign bus.in_ready = advance;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int LO = first_step(SHW, PIPE_STAGES, s);
        localparam int HI = LO + steps_in_stage(SHW, PIPE_STAGES, s) - 1;

        if (s == 0) begin : g_head
            assign v_in[s]    = bus.in_valid;
            assign d_in[s]    = bus.in_a;
            assign sh_in[s]   = bus.in_shamt;
            assign mode_in[s] = bus.in_mode;
            assign tag_in[s]  = bus.in_tag;
        end else begin : g_body
            assign v_in[s]    = v_q[s-1];
            assign d_in[s]    = d_q[s-1];
            assign sh_in[s]   = sh_q[s-1];
            assign mode_in[s] = mode_q[s-1];
            assign tag_in[s]  = tag_q[s-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .LO    (LO),
            .HI    (HI)
        ) u_stage (
            .a    (d_in[s]),
            .amt  (sh_in[s][HI:LO]),
            .mode (mode_in[s]),
            .r    (d_out[s])
        );
    end

    // NOTE: state is updated only with non-blocking assignments, and every stage
    // register is a real flop with a reset value, so no X ever reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                v_q[i]    <= 1'b0;
                d_q[i]    <= '0;
                sh_q[i]   <= '0;
                mode_q[i] <= SH_SRL;
                tag_q[i]  <= '0;
            end
        end else if (advance) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                v_q[i]    <= v_in[i];
                d_q[i]    <= d_out[i];
                sh_q[i]   <= sh_in[i];
                mode_q[i] <= mode_in[i];
                tag_q[i]  <= tag_in[i];
            end
        end
    end

    assign bus.out_valid = v_q[LAST];
    assign bus.out_r     = d_q[LAST];
    assign bus.out_tag   = tag_q[LAST];
    assign bus.out_zero  = (d_q[LAST] == '0);

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: directed vectors on a 32-bit/2-stage instance,
// then randomized traffic on that and 64-bit instances with 1, 3 and 6 stages.
module tb_pipelined_shifter;
    import shifter_pkg::*;

    localparam int N  = 4;
    localparam int TW = 5;

    function automatic int dw(input int g);
        return (g == 0) ? 32 : 64;
    endfunction

    function automatic int dp(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 6;
        endcase
    endfunction

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  vld;
    logic [N-1:0]  ordy;
    logic [63:0]   a   [N];
    logic [5:0]    sh  [N];
    logic [2:0]    md  [N];
    logic [TW-1:0] tg  [N];
    logic [N-1:0]  ir;
    logic [N-1:0]  ov;
    logic [N-1:0]  oz;
    logic [63:0]   r   [N];
    logic [TW-1:0] ot  [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W = dw(g);
        localparam int P = dp(g);

        pipelined_shifter_if #(.WIDTH(W), .TAG_W(TW)) bus ();

        assign bus.in_valid  = vld[g];
        assign bus.in_a      = a[g][W-1:0];
        assign bus.in_shamt  = sh[g][$clog2(W)-1:0];
        assign bus.in_mode   = md[g];
        assign bus.in_tag    = tg[g];
        assign bus.out_ready = ordy[g];
        assign ir[g]         = bus.in_ready;
        assign ov[g]         = bus.out_valid;
        assign oz[g]         = bus.out_zero;
        assign r[g]          = 64'(bus.out_r);
        assign ot[g]         = bus.out_tag;

        pipelined_shifter #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(TW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [63:0]   r;
        logic [TW-1:0] tag;
        int            cyc;
    } exp_t;

    exp_t exq [N][$];
    bit   chk_lat;

    // Reference: whole-word shift/rotate on a w-bit value using plain arithmetic.
    function automatic logic [63:0] ref_shift(input logic [63:0] a_in, input int s,
                                              input logic [2:0] m, input int w);
        logic [63:0] mask;
        logic [63:0] v;
        logic [63:0] fill;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        v    = a_in & mask;
        case (m)
            SH_SRL: return v >> s;
            SH_SLL: return (v << s) & mask;
            SH_SRA: begin
                fill = v[w-1] ? (mask & ~(mask >> s)) : 64'd0;
                return (v >> s) | fill;
            end
            SH_ROR:  return ((v >> s) | (v << (w - s))) & mask;
            SH_ROL:  return ((v << s) | (v >> (w - s))) & mask;
            default: return v;
        endcase
    endfunction

    task automatic check(input string name, input int d, input logic [63:0] obs,
                         input logic [63:0] expv);
        compared++;
        assert (obs === expv)
        else begin
            mismatched++;
            $error("FAIL %s dut%0d observed=%h expected=%h", name, d, obs, expv);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < N; d++) begin
            vld[d]  = 1'b0;
            ordy[d] = 1'b1;
            a[d]    = '0;
            sh[d]   = '0;
            md[d]   = '0;
            tg[d]   = '0;
        end
    endtask

    task automatic drive(input int d, input logic [63:0] av, input logic [5:0] s,
                         input logic [2:0] m, input logic [TW-1:0] t);
        vld[d] = 1'b1;
        a[d]   = av;
        sh[d]  = s;
        md[d]  = m;
        tg[d]  = t;
    endtask

    // One operation on instance d with an idle consumer; checks value, flags, latency.
    task automatic directed(input string name, input int d, input logic [63:0] av,
                            input logic [5:0] s, input logic [2:0] m,
                            input logic [TW-1:0] t, input logic [63:0] exp_r);
        int n;
        @(negedge clk);
        idle_all();
        drive(d, av, s, m, t);
        #1;
        check({name, "_in_ready"}, d, ir[d], 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            idle_all();
            n++;
            #1;
        end while (!ov[d] && n < 12);
        check({name, "_latency"}, d, n, dp(d));
        check(name, d, r[d], exp_r);
        check({name, "_tag"}, d, ot[d], t);
        check({name, "_zero"}, d, oz[d], exp_r == 64'd0);
    endtask

    // Called just after inputs are driven at a falling edge: scores what the next edge does.
    task automatic score();
        #1;
        for (int d = 0; d < N; d++) begin
            if (ov[d] && ordy[d]) begin
                check("expected_pending", d, 64'(exq[d].size() > 0), 1'b1);
                if (exq[d].size() > 0) begin
                    exp_t e;
                    e = exq[d].pop_front();
                    check("rnd_result", d, r[d], e.r);
                    check("rnd_tag", d, ot[d], e.tag);
                    check("rnd_zero", d, oz[d], e.r == 64'd0);
                    if (chk_lat) check("rnd_latency", d, cyc - e.cyc, dp(d));
                end
            end
            if (vld[d] && ir[d])
                exq[d].push_back('{ref_shift(a[d], int'(sh[d]), md[d], dw(d)), tg[d], cyc});
        end
    endtask

    task automatic rand_phase(input int cycles, input int ready_pct, input bit lat);
        chk_lat = lat;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) begin
                vld[d]  = ($urandom_range(0, 99) < 70);
                a[d]    = ($urandom_range(0, 15) == 0) ? 64'd0 : {$urandom(), $urandom()};
                sh[d]   = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, dw(d) - 1));
                md[d]   = 3'($urandom_range(0, 7));
                tg[d]   = TW'($urandom());
                ordy[d] = ($urandom_range(0, 99) < ready_pct);
            end
            score();
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            idle_all();
            score();
        end
        for (int d = 0; d < N; d++) check("drained", d, exq[d].size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            sent;
        int            got;
        int            stall_left;
        bit            stalled;
        logic [63:0]   snap_r;
        logic [TW-1:0] snap_tag;

        rst_n = 1'b0;
        idle_all();
        #2;
        for (int d = 0; d < N; d++) begin
            check("rst_out_valid", d, ov[d], 1'b0);
            check("rst_out_r", d, r[d], 64'd0);
            check("rst_out_tag", d, ot[d], 0);
            check("rst_out_zero", d, oz[d], 1'b1);
        end
        #10;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready_after_reset", 0, ir[0], 1'b1);

        // Basic modes, rotates, pass-through and zero flag.
        directed("sra_sign", 0, 64'h8000_0000, 6'd4, SH_SRA, 5'd3, 64'hF800_0000);
        directed("srl", 0, 64'h8000_0000, 6'd4, SH_SRL, 5'd4, 64'h0800_0000);
        directed("sll_31", 0, 64'h0000_0001, 6'd31, SH_SLL, 5'd5, 64'h8000_0000);
        directed("ror", 0, 64'h0000_00F1, 6'd4, SH_ROR, 5'd6, 64'h1000_000F);
        directed("rol", 0, 64'h8000_0001, 6'd1, SH_ROL, 5'd7, 64'h0000_0003);
        for (int m = 0; m < 8; m++)
            directed("shamt0", 0, 64'hC234_5679, 6'd0, 3'(m), 5'(m), 64'hC234_5679);
        directed("pass_111", 0, 64'hDEAD_BEEF, 6'd7, 3'b111, 5'd21, 64'hDEAD_BEEF);
        directed("srl_to_zero", 0, 64'h0000_000F, 6'd4, SH_SRL, 5'd9, 64'd0);
        for (int d = 1; d < N; d++)
            directed("sra64_63", d, 64'h8000_0000_0000_0000, 6'd63, SH_SRA, 5'd1, '1);

        // Back-pressure: tags 1..4 back to back, consumer stalls 3 cycles.
        sent       = 1;
        got        = 1;
        stall_left = 0;
        stalled    = 1'b0;
        snap_r     = '0;
        snap_tag   = '0;
        for (int c = 0; c < 30 && got <= 4; c++) begin
            @(negedge clk);
            idle_all();
            if (!stalled && ov[0]) begin
                stalled    = 1'b1;
                stall_left = 3;
                snap_r     = r[0];
                snap_tag   = ot[0];
            end
            ordy[0] = (stall_left == 0);
            if (sent <= 4) drive(0, 64'(sent), 6'(sent), SH_SLL, TW'(sent));
            #1;
            if (stall_left > 0) begin
                check("bp_in_ready", 0, ir[0], 1'b0);
                check("bp_out_valid", 0, ov[0], 1'b1);
                if (stall_left < 3) begin
                    check("bp_stable_r", 0, r[0], snap_r);
                    check("bp_stable_tag", 0, ot[0], snap_tag);
                end
                stall_left--;
            end
            if (ov[0] && ordy[0]) begin
                check("bp_tag_order", 0, ot[0], got);
                check("bp_result", 0, r[0], 64'(got << got));
                got++;
            end
            if (vld[0] && ir[0]) sent++;
        end
        check("bp_stall_seen", 0, stalled, 1'b1);
        check("bp_all_out", 0, got, 5);
        @(negedge clk);
        idle_all();
        #1;
        check("bp_no_duplicate", 0, ov[0], 1'b0);

        // Mid-flight reset: two ops accepted, reset pulsed between edges.
        @(negedge clk);
        idle_all();
        drive(0, 64'h5, 6'd1, SH_SLL, 5'd7);
        @(negedge clk);
        idle_all();
        drive(0, 64'h9, 6'd2, SH_SLL, 5'd8);
        @(negedge clk);
        idle_all();
        #1;
        check("mr_first_valid", 0, ov[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 0, ov[0], 1'b0);
        check("mr_out_r", 0, r[0], 64'd0);
        check("mr_out_zero", 0, oz[0], 1'b1);
        check("mr_out_tag", 0, ot[0], 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            idle_all();
            #1;
            for (int d = 0; d < N; d++) check("mr_no_stale", d, ov[d], 1'b0);
        end

        // Randomized traffic against the reference model.
        rand_phase(5000, 100, 1'b1);
        rand_phase(10000, 65, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
